// File: rtl/dw_lp_launch_pkg.sv
// dw_lp_launch_pkg
// Shared definitions for the low-power pipe launch controller:
//   state_t  : controller FSM states (IDLE, BUSY, DRAIN)
//   STATUS_W : width of the pipe status word carried with every result
package dw_lp_launch_pkg;

  localparam int STATUS_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/dw_lp_launch_fifo.sv
// dw_lp_launch_fifo
// First-word-fall-through result buffer with registered storage.
// The head entry is presented on rd_data whenever empty is low.
// A push into a full buffer is accepted only when a pop happens on the
// same edge; otherwise it is ignored (the parent flags the overflow).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (empties buffer)
//   push, wr_data   : write request and data
//   pop             : remove head entry (ignored when empty)
//   rd_data         : head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module dw_lp_launch_fifo
  import dw_lp_launch_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full buffer still takes a write when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dw_lp_pipe_launch_ctl.sv
// dw_lp_pipe_launch_ctl
// Launch/credit controller wrapped around a pipelined arithmetic unit.
// Operands are launched into the pipe with an incrementing tag, results
// are captured into a local FWFT buffer and handed downstream in order.
// Launches are only granted while every outstanding operation is
// guaranteed a slot in the result buffer.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   req_valid/req_ready/req_a/req_rnd : upstream operand handshake
//   launch/launch_id/op_a/op_rnd      : launch strobe, tag and operand to pipe
//   pipe_full/pipe_ovf                : pipe status
//   accept_n                          : active-low result accept to pipe
//   arrive/arrive_id/push_out_n/z/status : pipe result side
//   rsp_valid/rsp_ready/rsp_z/rsp_status/rsp_id : downstream result handshake
//   flush_req/flush_done              : drain request and completion pulse
//   outstanding                       : launched but not yet captured ops
//   err_ovf/err_id                    : sticky error flags
// Build option: define DW_LP_LAUNCH_ID_CHECK_EN to compare every captured
// arrive_id against the oldest outstanding tag (err_id); otherwise err_id=0.
module dw_lp_pipe_launch_ctl
  import dw_lp_launch_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [DATA_W-1:0]            req_a,
  input  logic [2:0]                   req_rnd,
  output logic                         launch,
  output logic [ID_W-1:0]              launch_id,
  output logic [DATA_W-1:0]            op_a,
  output logic [2:0]                   op_rnd,
  input  logic                         pipe_full,
  input  logic                         pipe_ovf,
  output logic                         accept_n,
  input  logic                         arrive,
  input  logic [ID_W-1:0]              arrive_id,
  input  logic                         push_out_n,
  input  logic [DATA_W-1:0]            z,
  input  logic [STATUS_W-1:0]          status,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_z,
  output logic [STATUS_W-1:0]          rsp_status,
  output logic [ID_W-1:0]              rsp_id,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic [$clog2(FIFO_DEPTH):0]  outstanding,
  output logic                         err_ovf,
  output logic                         err_id
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_W + STATUS_W + ID_W;

  state_t         state;
  logic [ID_W-1:0] id_cnt;
  logic           capture;
  logic           drop;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [EW-1:0]  fifo_rd_data;
  logic [CW:0]    credit_used;
  logic           unused_arrive;

  // push_out_n alone qualifies a result; arrive carries no extra meaning here.
  assign unused_arrive = arrive;

  // Results with nothing outstanding are stale (e.g. launched before a reset).
  assign capture = !push_out_n && (outstanding != '0);
  assign fifo_pop = rsp_valid && rsp_ready;
  assign drop     = capture && fifo_full && !fifo_pop;

  // Every launched op must be guaranteed a buffer slot when it lands.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign req_ready   = (state != DRAIN) && !flush_req && !pipe_full &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));

  assign launch    = req_valid && req_ready;
  assign launch_id = id_cnt;
  assign op_a      = req_a;
  assign op_rnd    = req_rnd;
  assign accept_n  = fifo_full;
  assign rsp_valid = !fifo_empty;
  assign {rsp_z, rsp_status, rsp_id} = fifo_rd_data;

  dw_lp_launch_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (capture),
    .wr_data ({z, status, arrive_id}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_cnt      <= '0;
      outstanding <= '0;
      err_ovf     <= 1'b0;
    end else begin
      if (launch) begin
        id_cnt <= id_cnt + ID_W'(1);
      end
      case ({launch, capture})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (pipe_ovf || drop) begin
        err_ovf <= 1'b1;
      end
    end
  end

  // Controller FSM; flush_done is a registered one-cycle pulse issued as
  // DRAIN hands back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            state <= DRAIN;
          end else if (launch) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (flush_req) begin
            state <= DRAIN;
          end else if ((outstanding == '0) && !launch) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if ((outstanding == '0) && fifo_empty) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DW_LP_LAUNCH_ID_CHECK_EN
  logic [ID_W-1:0] exp_id;

  // exp_id follows the oldest outstanding tag; results must land in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_id <= '0;
      err_id <= 1'b0;
    end else if (capture) begin
      if (arrive_id != exp_id) begin
        err_id <= 1'b1;
      end
      exp_id <= exp_id + ID_W'(1);
    end
  end
`else
  assign err_id = 1'b0;
`endif

endmodule

// File: tb/tb_dw_lp_pipe_launch_ctl.sv
// tb_dw_lp_pipe_launch_ctl
// Self-checking bench for dw_lp_pipe_launch_ctl (default parameters).
// A table of per-cycle vectors covers a single launch/result round trip;
// hand-written sequences cover ID wrap, buffer full, ID mismatch, flush
// and mid-operation reset. A small delay-line pipe model returns results
// in launch order with a programmable latency.
module tb_dw_lp_pipe_launch_ctl;

  localparam int LAT_MAX = 8;
`ifdef DW_LP_LAUNCH_ID_CHECK_EN
  localparam logic EXP_ERR_ID = 1'b1;
`else
  localparam logic EXP_ERR_ID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_a;
  logic [2:0]  req_rnd;
  logic        launch;
  logic [7:0]  launch_id;
  logic [31:0] op_a;
  logic [2:0]  op_rnd;
  logic        pipe_full, pipe_ovf, accept_n;
  logic        arrive;
  logic [7:0]  arrive_id;
  logic        push_out_n;
  logic [31:0] z;
  logic [7:0]  status;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_z;
  logic [7:0]  rsp_status, rsp_id;
  logic        flush_req, flush_done;
  logic [3:0]  outstanding;
  logic        err_ovf, err_id;

  int n_checks = 0;
  int n_pass   = 0;
  int launches, pops, pulses;

  // Pipe model delay line
  bit         pipe_en;
  int         lat;
  logic       pv  [LAT_MAX];
  logic [7:0] pid [LAT_MAX];

  typedef struct {
    logic        valid;
    logic [31:0] a;
    logic        push_n;
    logic [31:0] zin;
    logic [7:0]  aid;
    logic        rdy;
    logic        e_launch;
    logic [7:0]  e_lid;
    logic        e_ready;
    logic        e_rv;
    logic [7:0]  e_rid;
    logic [31:0] e_rz;
    logic [3:0]  e_out;
  } vec_t;

  vec_t tbl [7];

  dw_lp_pipe_launch_ctl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_rnd(req_rnd),
    .launch(launch), .launch_id(launch_id), .op_a(op_a), .op_rnd(op_rnd),
    .pipe_full(pipe_full), .pipe_ovf(pipe_ovf), .accept_n(accept_n),
    .arrive(arrive), .arrive_id(arrive_id), .push_out_n(push_out_n),
    .z(z), .status(status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
    .rsp_status(rsp_status), .rsp_id(rsp_id),
    .flush_req(flush_req), .flush_done(flush_done),
    .outstanding(outstanding), .err_ovf(err_ovf), .err_id(err_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic drive_pipe();
    push_out_n = !pv[lat-1];
    arrive     = pv[lat-1];
    arrive_id  = pid[lat-1];
    z          = 32'hA500_0000 | {24'h0, pid[lat-1]};
    status     = pid[lat-1];
  endtask

  // Sample this cycle, advance the pipe model, cross one rising edge.
  task automatic tick();
    #1;
    if (flush_done) pulses++;
    if (rsp_valid && rsp_ready) pops++;
    for (int i = LAT_MAX-1; i > 0; i--) begin
      pv[i]  = pv[i-1];
      pid[i] = pid[i-1];
    end
    pv[0]  = pipe_en && launch;
    pid[0] = launch_id;
    if (launch) launches++;
    @(posedge clk);
    #1;
    if (pipe_en) drive_pipe();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 0; req_a = '0; req_rnd = 3'd0;
    pipe_full = 0; pipe_ovf = 0;
    arrive = 0; arrive_id = '0; push_out_n = 1'b1; z = '0; status = '0;
    rsp_ready = 0; flush_req = 0;
    pipe_en = 0; lat = 3;
    for (int i = 0; i < LAT_MAX; i++) begin
      pv[i] = 1'b0; pid[i] = '0;
    end
    launches = 0; pops = 0; pulses = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    req_valid  = v.valid;
    req_a      = v.a;
    push_out_n = v.push_n;
    z          = v.zin;
    arrive_id  = v.aid;
    arrive     = !v.push_n;
    status     = 8'h00;
    rsp_ready  = v.rdy;
  endtask

  task automatic check_output(input int row, input vec_t v);
    string s;
    s = $sformatf("row%0d", row);
    check({s, "_launch"},    launch,      v.e_launch);
    check({s, "_launch_id"}, launch_id,   v.e_lid);
    check({s, "_req_ready"}, req_ready,   v.e_ready);
    check({s, "_rsp_valid"}, rsp_valid,   v.e_rv);
    check({s, "_outst"},     outstanding, v.e_out);
    if (v.valid) check({s, "_op_a"}, op_a, v.a);
    if (v.e_rv) begin
      check({s, "_rsp_id"}, rsp_id, v.e_rid);
      check({s, "_rsp_z"},  rsp_z,  v.e_rz);
    end
  endtask

  initial begin
    logic [7:0] exp_lid, exp_rid;
    int bad_lid, bad_rid, nresp, last_launch_cyc;
    bit seen;

    // Single launch, result four cycles later, popped the cycle after
    tbl[0] = '{1'b1, 32'h3F80_0000, 1'b1, 32'h0, 8'd0, 1'b0,
               1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 32'h0, 4'd0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 32'h0, 8'd0, 1'b0,
               1'b0, 8'd1, 1'b1, 1'b0, 8'd0, 32'h0, 4'd1};
    tbl[2] = tbl[1];
    tbl[3] = tbl[1];
    tbl[4] = '{1'b0, 32'h0, 1'b0, 32'h3F80_0000, 8'd0, 1'b0,
               1'b0, 8'd1, 1'b1, 1'b0, 8'd0, 32'h0, 4'd1};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 32'h0, 8'd0, 1'b1,
               1'b0, 8'd1, 1'b1, 1'b1, 8'd0, 32'h3F80_0000, 4'd0};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 32'h0, 8'd0, 1'b1,
               1'b0, 8'd1, 1'b1, 1'b0, 8'd0, 32'h0, 4'd0};

    apply_reset();
    req_valid = 1; pipe_full = 1;
    #1;
    check("pipe_full_ready", req_ready, 1'b0);
    check("pipe_full_launch", launch, 1'b0);
    pipe_full = 0;
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(tbl[i]);
      #1;
      check_output(i, tbl[i]);
      @(posedge clk);
      #1;
    end

    // 300 back-to-back launches, ID wrap and in-order responses
    apply_reset();
    pipe_en = 1; lat = 3; rsp_ready = 1;
    exp_lid = 0; exp_rid = 0; bad_lid = 0; bad_rid = 0; nresp = 0;
    last_launch_cyc = -1;
    for (int c = 0; c < 1000 && nresp < 300; c++) begin
      req_valid = (launches < 300);
      #1;
      if (launch) begin
        if (launch_id !== exp_lid) bad_lid++;
        exp_lid++;
        if (launches == 299) last_launch_cyc = c;
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_id !== exp_rid) bad_rid++;
        exp_rid++;
        nresp++;
      end
      tick();
    end
    check("b2b_resp_count", nresp, 300);
    check("b2b_launch_ids", bad_lid, 0);
    check("b2b_rsp_order", bad_rid, 0);
    check("b2b_no_stall", last_launch_cyc, 299);
    check("b2b_wrapped_id", launch_id, 8'd44);
    check("b2b_err_ovf", err_ovf, 1'b0);
    check("b2b_err_id", err_id, 1'b0);

    // Eight results held downstream: buffer full, then drain in order
    apply_reset();
    pipe_en = 1; lat = 3; rsp_ready = 0; req_valid = 1;
    for (int b = 0; b < 40 && launches < 8; b++) tick();
    #1;
    check("full_credit_block", req_ready, 1'b0);
    req_valid = 0;
    seen = 0;
    for (int b = 0; b < 20; b++) begin
      #1;
      if (accept_n) begin seen = 1; break; end
      tick();
    end
    check("full_seen", seen, 1'b1);
    check("full_accept_n", accept_n, 1'b1);
    check("full_req_ready", req_ready, 1'b0);
    check("full_outst", outstanding, 4'd0);
    rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("drain%0d_valid", i), rsp_valid, 1'b1);
      check($sformatf("drain%0d_id", i), rsp_id, i[7:0]);
      if (i == 1) check("drain_accept_n", accept_n, 1'b0);
      tick();
    end
    #1;
    check("drain_empty", rsp_valid, 1'b0);
    check("drain_ready", req_ready, 1'b1);

    // Out-of-order tag: 5 arrives where 3 is expected
    apply_reset();
    rsp_ready = 1; req_valid = 1;
    repeat (4) tick();
    req_valid = 0;
    push_out_n = 0; arrive = 1;
    for (int i = 0; i < 3; i++) begin
      arrive_id = i[7:0];
      tick();
    end
    #1;
    check("id_inorder_err", err_id, 1'b0);
    arrive_id = 8'd5;
    tick();
    push_out_n = 1; arrive = 0;
    #1;
    check("id_mismatch_err", err_id, EXP_ERR_ID);
    repeat (3) tick();
    check("id_err_sticky", err_id, EXP_ERR_ID);
    check("id_outst", outstanding, 4'd0);

    // Flush with three outstanding
    apply_reset();
    pipe_en = 1; lat = 4; rsp_ready = 1; req_valid = 1;
    repeat (3) tick();
    flush_req = 1;
    #1;
    check("flush_outst", outstanding, 4'd3);
    check("flush_ready", req_ready, 1'b0);
    check("flush_blocks_launch", launch, 1'b0);
    tick();
    check("drain_ready_held", req_ready, 1'b0);
    tick();
    flush_req = 0;
    #1;
    check("drain_ready_released", req_ready, 1'b0);
    req_valid = 0;
    seen = 0;
    for (int b = 0; b < 30; b++) begin
      #1;
      if (flush_done) begin seen = 1; break; end
      tick();
    end
    check("flush_done_seen", seen, 1'b1);
    check("flush_pops", pops, 3);
    check("flush_idle_ready", req_ready, 1'b1);
    repeat (5) tick();
    check("flush_one_pulse", pulses, 1);

    // Reset with four in flight and pipe_ovf high
    apply_reset();
    pipe_en = 1; lat = 6; rsp_ready = 1; req_valid = 1;
    repeat (4) tick();
    req_valid = 0;
    #1;
    check("rst_pre_outst", outstanding, 4'd4);
    pipe_ovf = 1; rst = 1;
    #1;
    check("rst_outst", outstanding, 4'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_accept_n", accept_n, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_err_ovf", err_ovf, 1'b0);
    check("rst_err_id", err_id, 1'b0);
    check("rst_launch_id", launch_id, 8'd0);
    repeat (2) tick();
    pipe_ovf = 0;
    #1 rst = 0;
    repeat (8) tick();
    check("post_rst_err_ovf", err_ovf, 1'b0);
    check("post_rst_err_id", err_id, 1'b0);
    check("post_rst_outst", outstanding, 4'd0);
    check("post_rst_rsp_valid", rsp_valid, 1'b0);
    pipe_ovf = 1;
    tick();
    pipe_ovf = 0;
    #1;
    check("pipe_ovf_sets", err_ovf, 1'b1);
    repeat (2) tick();
    check("pipe_ovf_sticky", err_ovf, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
